// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin arbiter/sequencer sharing one multi-cycle multiplier
// Grants one requester at a time, runs the multiplier under a watchdog, returns the product.
module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 128,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [2*W-1:0]      rsp_prod,
    output logic                rsp_err,
    output logic                mul_start,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_c,
    output logic                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic             err_q, err_d;

    logic             found;
    logic [IW-1:0]    grant;
    logic [IW:0]      j_sum;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        j_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (j_sum >= (IW+1)'(NREQ)) begin
                j_sum = j_sum - (IW+1)'(NREQ);
            end
            if (req_valid[j_sum[IW-1:0]]) begin
                found = 1'b1;
                grant = j_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready[grant] = 1'b1;
                    a_d              = req_a[grant*W +: W];
                    b_d              = req_b[grant*W +: W];
                    owner_d          = grant;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the final watchdog cycle still counts as success.
                if (mul_done) begin
                    prod_d  = mul_c;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign rsp_prod = prod_q;
    assign rsp_err  = err_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - directed self-checking bench for mul_share_arb
// Multiplier model on the falling edge with programmable latency and stray-done injection.
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 128;
    localparam int TO   = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a = '0;
    logic [NREQ*W-1:0]   req_b = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [2*W-1:0]      rsp_prod;
    logic                rsp_err;
    logic                mul_start;
    logic [W-1:0]        mul_a;
    logic [W-1:0]        mul_b;
    logic                mul_done = 1'b0;
    logic [2*W-1:0]      mul_c = '0;
    logic                busy;

    mul_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_err   (rsp_err),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_c     (mul_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int           lat        = 4;
    bit           mul_en     = 1'b1;
    int           inj_req_n  = 0;
    int           inj_done_n = 0;
    logic [255:0] inj_c      = '0;
    int           dly        = 0;
    bit           pend       = 1'b0;
    logic [255:0] prod_m     = '0;

    always @(negedge clk) begin
        mul_done = 1'b0;
        mul_c    = {8{32'hDEADBEEF}};
        if (mul_start && mul_en) begin
            pend   = 1'b1;
            dly    = lat;
            prod_m = {128'b0, mul_a} * {128'b0, mul_b};
        end else if (pend) begin
            dly--;
            if (dly == 0) begin
                pend     = 1'b0;
                mul_done = 1'b1;
                mul_c    = prod_m;
            end
        end
        if (inj_req_n != inj_done_n) begin
            inj_done_n = inj_req_n;
            mul_done   = 1'b1;
            mul_c      = inj_c;
        end
    end

    task automatic send(input int idx, input logic [127:0] a, input logic [127:0] b);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx]    = 1'b1;
        #1;
        check("grant", req_ready, 256'(1 << idx));
        @(negedge clk);
        req_valid[idx] = 1'b0;
        check("mul_start", mul_start, 1);
        check("mul_a", mul_a, a);
        check("mul_b", mul_b, b);
        check("busy", busy, 1);
        check("ready_issue", req_ready, 0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", 256'(|rsp_valid), 1);
    endtask

    task automatic take(input int idx);
        rsp_ready      = '0;
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
        check("rsp_done", rsp_valid, 0);
    endtask

    int           n;
    int           order [11] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3};
    logic [255:0] prods [4]  = '{256'd10, 256'd22, 256'd36, 256'd52};
    logic [127:0] ones;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_prod", rsp_prod, 0);
        check("rst_err", rsp_err, 0);
        check("rst_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fairness with all requesters pending, then with requester 1 dropped.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 128'(i + 1);
            req_b[i*W +: W] = 128'(i + 10);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 11; k++) begin
            wait_rsp(n);
            check("rr_owner", rsp_valid, 256'(1 << order[k]));
            check("rr_prod", rsp_prod, prods[order[k]]);
            if (k == 7) req_valid[1] = 1'b0;
            if (k == 10) req_valid = '0;
            take(order[k]);
        end

        // Single request, L=4.
        send(2, 128'h3, 128'h5);
        wait_rsp(n);
        check("lat_l4", 256'(n), 5);
        check("single_owner", rsp_valid, 4'b0100);
        check("single_prod", rsp_prod, 256'hF);
        check("single_err", rsp_err, 0);
        take(2);

        // Full-width operands.
        ones = '1;
        send(1, ones, ones);
        wait_rsp(n);
        check("full_prod", rsp_prod,
              {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1});
        take(1);

        // Backpressure with stray done pulses and a pending request.
        send(0, 128'd7, 128'd9);
        wait_rsp(n);
        check("bp_prod0", rsp_prod, 256'd63);
        rsp_ready = 4'b1110;
        req_a[2*W +: W] = 128'd1;
        req_b[2*W +: W] = 128'd1;
        req_valid[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 2 || c == 6) begin
                inj_c = {8{$urandom}};
                inj_req_n++;
            end
            @(negedge clk);
            check("bp_valid", rsp_valid, 4'b0001);
            check("bp_prod", rsp_prod, 256'd63);
            check("bp_ready", req_ready, 0);
        end
        req_valid[2] = 1'b0;
        rsp_ready    = '0;
        take(0);

        // Timeout: multiplier never answers.
        mul_en = 1'b0;
        send(3, 128'd2, 128'd3);
        wait_rsp(n);
        check("to_lat", 256'(n), 17);
        check("to_owner", rsp_valid, 4'b1000);
        check("to_err", rsp_err, 1);
        check("to_prod", rsp_prod, 0);
        take(3);
        mul_en = 1'b1;

        // Done lands on the final watchdog cycle.
        lat = 16;
        send(1, 128'd6, 128'd7);
        wait_rsp(n);
        check("co_lat", 256'(n), 17);
        check("co_err", rsp_err, 0);
        check("co_prod", rsp_prod, 256'd42);
        take(1);
        lat = 4;

        // Reset two cycles after mul_start, then a late done.
        send(3, 128'd4, 128'd5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_valid", rsp_valid, 0);
        check("ar_start", mul_start, 0);
        check("ar_mul_a", mul_a, 0);
        check("ar_prod", rsp_prod, 0);
        check("ar_err", rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("ar_no_rsp", rsp_valid, 0);
            check("ar_idle", busy, 0);
        end
        check("ar_prod_kept", rsp_prod, 0);
        req_a[0 +: W] = 128'd8;
        req_b[0 +: W] = 128'd8;
        req_valid     = 4'hF;
        #1;
        check("ar_ptr0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        check("ar_owner", rsp_valid, 4'b0001);
        check("ar_prod_new", rsp_prod, 256'd64);
        take(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one multi-cycle 128x128 multiplier among up to NREQ requesters in the SM2 signature datapath (modular reduction, point add/double, and scalar units). It accepts one operand pair at a time, starts the multiplier, waits for completion or a watchdog timeout, then returns the 256-bit product to the granted requester over a valid/ready handshake.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 128, operand width; product width is 2*W
- TIMEOUT, 64, maximum cycles in WAIT before error completion (>= multiplier latency + 2)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  one-hot accept pulse; a transfer happens when req_valid[i] & req_ready[i]
- req_a  in  NREQ*W  packed operands A; slice i is [i*W +: W]
- req_b  in  NREQ*W  packed operands B
- rsp_valid  out  NREQ  one-hot response valid for the owner
- rsp_ready  in  NREQ  per-requester response accept
- rsp_prod  out  2*W  product, shared by all requesters, qualified by rsp_valid
- rsp_err  out  1  1 = timeout completion; rsp_prod is 0
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a, mul_b  out  W  registered operands, stable from the mul_start cycle until the multiplier completes
- mul_done  in  1  one-cycle completion pulse from the multiplier
- mul_c  in  2*W  multiplier product, valid when mul_done = 1
- busy  out  1  1 in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Search req_valid starting at round-robin pointer ptr and wrap modulo NREQ; first set bit wins.
  - Assert req_ready for the winner only, combinationally, in the same cycle.
  - Latch req_a/req_b slice into mul_a/mul_b, record owner index, go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE: mul_start = 1 for exactly one cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - Watchdog counter increments each cycle.
  - On mul_done: capture mul_c into rsp_prod, rsp_err = 0, go to RESP.
  - If counter reaches TIMEOUT-1 with no mul_done: rsp_prod = 0, rsp_err = 1, go to RESP.
  - If mul_done and the timeout coincide, mul_done wins (err = 0).
- RESP:
  - rsp_valid[owner] = 1, all other bits 0; rsp_prod/rsp_err held stable.
  - On rsp_ready[owner]: ptr = (owner+1) mod NREQ, go to IDLE.
  - rsp_ready on non-owner bits is ignored.
- mul_done outside WAIT is ignored and does not alter rsp_prod.
- req_valid deasserted before acceptance is legal and produces no transfer.
- No operand arithmetic in this block; the product is passed through at full width 2*W with no truncation.

## Timing
- Reset values: state IDLE, ptr 0, req_ready 0, rsp_valid 0, rsp_prod 0, rsp_err 0, mul_start 0, mul_a/mul_b 0, busy 0.
- Reset asserted mid-operation aborts the transaction immediately. No response is issued, and a later stray mul_done is ignored.
- Accept in cycle T; mul_start in T+1. With mul_done in T+1+L, rsp_valid rises in T+2+L.
- If rsp_ready is already high, the response completes in T+2+L. The next accept can occur in T+3+L.
- Throughput: one multiply per L+3 cycles minimum; the arbiter never overlaps transactions.
- Timeout completion: rsp_valid rises TIMEOUT+1 cycles after mul_start.
- req_ready is never high outside IDLE. At most one bit of req_ready or rsp_valid is high in any cycle.

## Test plan
- Single request: requester 2 sends a=0x3, b=0x5; mul model with L=4 -> req_ready[2] in T, mul_start in T+1, rsp_valid[2] with rsp_prod=0xF, rsp_err=0 in T+6.
- Full-width operands: a=b=2^128-1 -> rsp_prod = 2^256 - 2^129 + 1; no truncation of the upper bits.
- Fairness: all four req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3. Then drop req 1 and grant from ptr=0 -> order 0,2,3.
- Backpressure: hold rsp_ready[owner]=0 for 10 cycles -> rsp_valid and rsp_prod stay stable, req_ready stays 0, and mul_done pulses injected in RESP do not change rsp_prod.
- Timeout: TIMEOUT=16, model never asserts mul_done -> rsp_valid[owner] with rsp_err=1, rsp_prod=0, 17 cycles after mul_start. A done/timeout coincidence -> err=0.
- Reset mid-WAIT: assert rst two cycles after mul_start, release, then inject a late mul_done -> all outputs at reset values, no rsp_valid, ptr=0 on the next grant.
